byte_encode_seq: RTL and testbench
==================================

BYTE_ENCODE_SEQ -- requirements
Module: byte_encode_seq

Interface
REQ-001 The block SHALL expose parameter IN_WIDTH, default 16, giving the coefficient input width (IN_WIDTH >= 12).
REQ-002 The block SHALL have one clock and one reset: clk_i  input  1  rising-edge clock; rst_ni  input  1  asynchronous, active-low reset.
REQ-003 The block SHALL have port start_i  input  1  one-cycle request to begin encoding one 256-coefficient polynomial.
REQ-004 The block SHALL have port d_i  input  4  bits per coefficient, sampled on an accepted start_i.
REQ-005 The block SHALL have ports coef_valid_i  input  1, coef_i  input  IN_WIDTH, coef_ready_o  output  1, forming the coefficient stream; transfer occurs when valid and ready are both 1.
REQ-006 The block SHALL have ports byte_valid_o  output  1, byte_o  output  8, byte_ready_i  input  1, byte_last_o  output  1, forming the byte stream.
REQ-007 The block SHALL have ports busy_o  output  1  (encoding in progress), done_o  output  1  (one-cycle completion pulse), err_o  output  1  (sticky range error).

Function
REQ-008 The FSM SHALL have states IDLE, RUN and DONE.
REQ-009 In IDLE, start_i=1 with d_i in 1..12 SHALL latch d, clear the coefficient counter, bit counter, accumulator and err_o, and move to RUN on the next edge; start_i with d_i of 0 or 13..15 SHALL be ignored.
REQ-010 start_i in RUN or DONE SHALL be ignored.
REQ-011 coef_ready_o SHALL be 1 only in RUN while the bit count is < 8 and fewer than 256 coefficients have been accepted.
REQ-012 An accepted coefficient SHALL have its low d bits OR-ed into a 20-bit accumulator at bit position equal to the bit count, and the bit count SHALL increase by d; upper bits SHALL be discarded.
REQ-013 byte_valid_o SHALL be 1 whenever the bit count is >= 8, with byte_o = accumulator[7:0]; this gives LSB-first packing, so bit i*d+j of the output stream equals bit j of coefficient i.
REQ-014 On a byte handshake, the accumulator SHALL shift right by 8 and the bit count SHALL decrease by 8.
REQ-015 byte_o and byte_valid_o SHALL stay stable while byte_valid_o=1 and byte_ready_i=0.
REQ-016 Acceptance of a coefficient and emission of a byte SHALL never occur in the same cycle, because REQ-011 and REQ-013 are mutually exclusive.
REQ-017 Latency SHALL be one cycle: a coefficient accepted on edge N that makes the bit count >= 8 asserts byte_valid_o after edge N.
REQ-018 byte_last_o SHALL be 1 together with byte_valid_o for byte index 32*d-1 only.
REQ-019 After the last byte handshake, the FSM SHALL enter DONE, assert done_o for exactly one cycle, and return to IDLE on the next edge.
REQ-020 busy_o SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-021 Exactly 32*d bytes SHALL be emitted per polynomial, with no residual bits.

Reset
REQ-022 When rst_ni=0, the block SHALL asynchronously enter IDLE with all outputs 0 (coef_ready_o, byte_valid_o, byte_o, byte_last_o, busy_o, done_o, err_o), and with the accumulator, counters and latched d cleared.
REQ-023 A reset in mid-operation SHALL abandon the polynomial; after release, no byte output SHALL occur until a new accepted start_i.

Configuration
REQ-024 When macro BYTE_ENCODE_RANGE_CHK_EN is defined, an accepted coefficient SHALL set err_o (sticky until the next accepted start_i) if it is >= 2^d, or if it is >= 3329 when d=12; encoding SHALL continue with masked bits.
REQ-025 When BYTE_ENCODE_RANGE_CHK_EN is undefined, the block SHALL contain no checking logic and err_o SHALL be tied to 0.

Verification
REQ-026 Scenario: d=1, coefficients i%2 for i=0..255, byte_ready_i=1 -> 32 bytes, all 0xAA; byte_last_o on byte 31; one done_o pulse.
REQ-027 Scenario: d=8, coefficients i -> bytes 0x00..0xFF in order; a coefficient is accepted no more often than every 2 cycles.
REQ-028 Scenario: d=12, coefficients 0x001, 0x002, then 254 zeros -> bytes 0x01, 0x20, 0x00, ... for 384 bytes total, last byte flagged.
REQ-029 Scenario: d=12 with random byte_ready_i stalls -> byte_o stable while stalled; output identical to the no-stall run.
REQ-030 Scenario: rst_ni pulled low after 100 d=8 bytes -> all outputs 0 immediately; a new start with d=1 then produces exactly 32 correct bytes.
REQ-031 Scenario: with BYTE_ENCODE_RANGE_CHK_EN defined, d=4 and coefficient 0x1F at index 0 -> err_o=1 from the next cycle, byte 0 low nibble = 0xF; the next start clears err_o.

Source files
------------

// File: rtl/byte_encode_seq.sv
// Packs a 256-coefficient polynomial into an LSB-first byte stream, d bits per coefficient.
// Optional feature: define BYTE_ENCODE_RANGE_CHK_EN to flag out-of-range coefficients on err_o.
module byte_encode_seq #(
   parameter int unsigned IN_WIDTH = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                start_i,
   input  logic [3:0]          d_i,
   input  logic                coef_valid_i,
   input  logic [IN_WIDTH-1:0] coef_i,
   output logic                coef_ready_o,
   output logic                byte_valid_o,
   output logic [7:0]          byte_o,
   input  logic                byte_ready_i,
   output logic                byte_last_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);

   localparam int unsigned ACC_W  = 20;
   localparam int unsigned BCNT_W = 5;
   localparam int unsigned CNT_W  = 9;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [3:0]         d_q, d_d;
   logic [CNT_W-1:0]   coef_cnt_q, coef_cnt_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               coef_ready_q, coef_ready_d;
   logic               byte_valid_q, byte_valid_d;
   logic               byte_last_q, byte_last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               coef_acc, byte_acc;
   logic [IN_WIDTH-1:0] coef_mask;
   logic [ACC_W-1:0]   coef_bits;
   logic [CNT_W-1:0]   last_idx_q, last_idx_d;

`ifdef BYTE_ENCODE_RANGE_CHK_EN
   logic err_q, err_d;
   logic coef_bad;
`endif

   assign coef_acc  = coef_valid_i & coef_ready_q;
   assign byte_acc  = byte_valid_q & byte_ready_i;
   assign coef_mask = (IN_WIDTH'(1) << d_q) - IN_WIDTH'(1);
   assign coef_bits = ACC_W'(coef_i & coef_mask);
   assign last_idx_q = {d_q, 5'd0} - CNT_W'(1);

`ifdef BYTE_ENCODE_RANGE_CHK_EN
   // Out of range: any bit at or above d, or not a valid mod-3329 residue at d=12
   assign coef_bad = ((coef_i >> d_q) != '0) ||
                     ((d_q == 4'd12) && (coef_i >= IN_WIDTH'(3329)));
`endif

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d    = state_q;
      d_d        = d_q;
      coef_cnt_d = coef_cnt_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      acc_d      = acc_q;
`ifdef BYTE_ENCODE_RANGE_CHK_EN
      err_d      = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start_i && (d_i != 4'd0) && (d_i <= 4'd12)) begin
               d_d        = d_i;
               coef_cnt_d = '0;
               byte_cnt_d = '0;
               bit_cnt_d  = '0;
               acc_d      = '0;
`ifdef BYTE_ENCODE_RANGE_CHK_EN
               err_d      = 1'b0;
`endif
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            // coef_ready and byte_valid are exclusive, so at most one branch fires
            if (coef_acc) begin
               acc_d      = acc_q | (coef_bits << bit_cnt_q);
               bit_cnt_d  = bit_cnt_q + BCNT_W'(d_q);
               coef_cnt_d = coef_cnt_q + CNT_W'(1);
`ifdef BYTE_ENCODE_RANGE_CHK_EN
               if (coef_bad) err_d = 1'b1;
`endif
            end else if (byte_acc) begin
               acc_d      = acc_q >> 8;
               bit_cnt_d  = bit_cnt_q - BCNT_W'(8);
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (byte_cnt_q == last_idx_q) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      last_idx_d   = {d_d, 5'd0} - CNT_W'(1);
      coef_ready_d = (state_d == S_RUN) && (bit_cnt_d < BCNT_W'(8)) && !coef_cnt_d[8];
      byte_valid_d = (state_d == S_RUN) && (bit_cnt_d >= BCNT_W'(8));
      byte_last_d  = byte_valid_d && (byte_cnt_d == last_idx_d);
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         d_q          <= '0;
         coef_cnt_q   <= '0;
         byte_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         acc_q        <= '0;
         coef_ready_q <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         d_q          <= d_d;
         coef_cnt_q   <= coef_cnt_d;
         byte_cnt_q   <= byte_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         acc_q        <= acc_d;
         coef_ready_q <= coef_ready_d;
         byte_valid_q <= byte_valid_d;
         byte_last_q  <= byte_last_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

`ifdef BYTE_ENCODE_RANGE_CHK_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else         err_q <= err_d;
   end
   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign coef_ready_o = coef_ready_q;
   assign byte_valid_o = byte_valid_q;
   assign byte_o       = acc_q[7:0];
   assign byte_last_o  = byte_last_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_byte_encode_seq.sv
// Randomized bench for byte_encode_seq against a bit-stream reference model.
module tb_byte_encode_seq;

   localparam int unsigned IN_W = 16;

   logic            clk = 1'b0;
   logic            rst_ni = 1'b0;
   logic            start_i = 1'b0;
   logic [3:0]      d_i = 4'd0;
   logic            coef_valid_i = 1'b0;
   logic [IN_W-1:0] coef_i = '0;
   logic            coef_ready_o;
   logic            byte_valid_o;
   logic [7:0]      byte_o;
   logic            byte_ready_i = 1'b0;
   logic            byte_last_o;
   logic            busy_o;
   logic            done_o;
   logic            err_o;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int unsigned coefs[256];

   byte_encode_seq #(.IN_WIDTH(IN_W)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .d_i(d_i),
      .coef_valid_i(coef_valid_i), .coef_i(coef_i), .coef_ready_o(coef_ready_o),
      .byte_valid_o(byte_valid_o), .byte_o(byte_o), .byte_ready_i(byte_ready_i),
      .byte_last_o(byte_last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_coef_ready"}, 32'(coef_ready_o), 32'd0);
      check({tag, "_byte_valid"}, 32'(byte_valid_o), 32'd0);
      check({tag, "_byte"},       32'(byte_o),       32'd0);
      check({tag, "_last"},       32'(byte_last_o),  32'd0);
      check({tag, "_busy"},       32'(busy_o),       32'd0);
      check({tag, "_done"},       32'(done_o),       32'd0);
      check({tag, "_err"},        32'(err_o),        32'd0);
   endtask

   // Encode coefs[] with d bits each; stop early after abort_at bytes if smaller than 32*d
   task automatic run_poly(input int unsigned d, input int unsigned rdy_pct,
                           input int unsigned vld_pct, input int unsigned abort_at);
      int unsigned n_bytes;
      logic [7:0]  exp_q[$];
      logic [7:0]  b;
      logic [7:0]  held;
      int unsigned bi, ci, cyc, last_acc, pos;
      bit          have_acc, err_exp, stalled, byte_x, coef_x;
      n_bytes = 32 * d;
      for (int k = 0; k < int'(n_bytes); k++) begin
         b = 8'd0;
         for (int t = 0; t < 8; t++) begin
            pos  = int'(k) * 8 + t;
            b[t] = 1'((coefs[pos / d] >> (pos % d)) & 1);
         end
         exp_q.push_back(b);
      end
      bi = 0; ci = 0; cyc = 0; last_acc = 0;
      have_acc = 0; err_exp = 0; stalled = 0; held = 8'd0;

      @(negedge clk);
      start_i = 1'b1; d_i = 4'(d);
      @(negedge clk);
      start_i = 1'b0;
      check("busy_after_start", 32'(busy_o), 32'd1);
      while (bi < abort_at && bi < n_bytes) begin
         if (cyc > 8000) begin
            check("timeout_bytes", bi, n_bytes);
            break;
         end
         check("ready_valid_excl", 32'(coef_ready_o & byte_valid_o), 32'd0);
         check("err_flag", 32'(err_o), 32'(err_exp));
         if (stalled) begin
            check("stall_valid", 32'(byte_valid_o), 32'd1);
            check("stall_data",  32'(byte_o),       32'(held));
         end
         byte_ready_i = ($urandom_range(99) < rdy_pct);
         coef_valid_i = (ci < 256) && ($urandom_range(99) < vld_pct);
         coef_i       = IN_W'(coefs[ci < 256 ? ci : 0]);
         start_i      = ($urandom_range(15) == 0);
         d_i          = 4'($urandom_range(15));
         byte_x = byte_valid_o && byte_ready_i;
         coef_x = coef_valid_i && coef_ready_o;
         if (byte_x) begin
            check("byte_data", 32'(byte_o), 32'(exp_q[bi]));
            check("byte_last", 32'(byte_last_o), 32'(bi == n_bytes - 1));
            bi++;
         end
         stalled = byte_valid_o && !byte_ready_i;
         held    = byte_o;
         if (coef_x) begin
            if (d == 8 && have_acc) check("accept_gap", 32'(cyc - last_acc >= 2), 32'd1);
            have_acc = 1; last_acc = cyc;
`ifdef BYTE_ENCODE_RANGE_CHK_EN
            if (coefs[ci] >= (32'd1 << d) || (d == 12 && coefs[ci] >= 3329)) err_exp = 1;
`endif
            ci++;
         end
         cyc++;
         @(negedge clk);
      end
      start_i = 1'b0; coef_valid_i = 1'b0;
      if (bi == n_bytes) begin
         check("coefs_consumed", ci, 32'd256);
         check("done_pulse",  32'(done_o),       32'd1);
         check("done_busy",   32'(busy_o),       32'd1);
         check("done_nobyte", 32'(byte_valid_o), 32'd0);
         check("done_err",    32'(err_o),        32'(err_exp));
         @(negedge clk);
         check("done_end",    32'(done_o),       32'd0);
         check("idle_busy",   32'(busy_o),       32'd0);
         check("idle_ready",  32'(coef_ready_o), 32'd0);
         check("idle_err",    32'(err_o),        32'(err_exp));
      end
   endtask

   initial begin
      // Reset state
      #1;
      check_all_zero("in_reset");
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      check_all_zero("after_reset");

      // Illegal d values are ignored in IDLE
      foreach (coefs[i]) coefs[i] = 0;
      for (int k = 0; k < 3; k++) begin
         start_i = 1'b1;
         d_i = (k == 0) ? 4'd0 : (k == 1) ? 4'd13 : 4'd15;
         @(negedge clk);
         start_i = 1'b0;
         @(negedge clk);
         check("bad_d_busy", 32'(busy_o), 32'd0);
      end

      // d=1 alternating bits
      foreach (coefs[i]) coefs[i] = i % 2;
      run_poly(1, 100, 100, 9999);

      // d=8 identity
      foreach (coefs[i]) coefs[i] = i;
      run_poly(8, 100, 100, 9999);

      // d=12 sparse
      foreach (coefs[i]) coefs[i] = 0;
      coefs[0] = 1; coefs[1] = 2;
      run_poly(12, 100, 100, 9999);

      // d=12 random residues, with and without output stalls
      foreach (coefs[i]) coefs[i] = $urandom_range(3328);
      run_poly(12, 100, 100, 9999);
      run_poly(12, 40, 100, 9999);

      // Random widths, random stalls and source gaps, junk above bit d
      for (int r = 0; r < 6; r++) begin
         foreach (coefs[i]) coefs[i] = $urandom_range(16'hFFFF);
         run_poly($urandom_range(12, 1), 65, 75, 9999);
      end

      // Reset mid-polynomial
      foreach (coefs[i]) coefs[i] = i;
      run_poly(8, 100, 100, 100);
      coef_valid_i = 1'b1;
      byte_ready_i = 1'b1;
      rst_ni = 1'b0;
      #1;
      check_all_zero("mid_reset");
      @(negedge clk);
      rst_ni = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_valid", 32'(byte_valid_o), 32'd0);
         check("post_reset_busy",  32'(busy_o),       32'd0);
      end
      coef_valid_i = 1'b0;
      foreach (coefs[i]) coefs[i] = (i * 7 + 3) % 2;
      run_poly(1, 100, 100, 9999);

`ifdef BYTE_ENCODE_RANGE_CHK_EN
      // Out-of-range coefficient sets err, next start clears it
      foreach (coefs[i]) coefs[i] = $urandom_range(15);
      coefs[0] = 32'h1F;
      run_poly(4, 100, 100, 9999);
      check("err_sticky_idle", 32'(err_o), 32'd1);
      foreach (coefs[i]) coefs[i] = $urandom_range(15);
      run_poly(4, 100, 100, 9999);
      foreach (coefs[i]) coefs[i] = 3329;
      run_poly(12, 100, 100, 9999);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
